// File: rtl/hb_decim_ctrl.sv
// -----------------------------------------------------------------------------
// hb_decim_ctrl
// Sequencer for the Rx half-band decimate-by-2 stage.
//
// Incoming samples are grouped into even/odd polyphase pairs. Each completed
// pair is presented on e0_data (even) / e1_data (odd) together with a
// one-cycle branch_en advance strobe. The first FILL_LAT pairs only prime the
// branch pipelines. After that, out_valid follows branch_en by one cycle. When
// enable is removed, the branch delay lines are flushed with FILL_LAT zero
// strobes and the block then returns to IDLE.
//
// Ports
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   enable     in   1       1 = run, 0 = stop (flush, then idle)
//   in_valid   in   1       in_sample valid this cycle
//   in_sample  in   DATA_W  signed input sample
//   e0_data    out  DATA_W  even-phase sample, held between advances
//   e1_data    out  DATA_W  odd-phase sample, held between advances
//   branch_en  out  1       one-cycle advance strobe for both branches
//   out_valid  out  1       decimated combiner output valid
//   state      out  2       0 IDLE, 1 FILL, 2 RUN, 3 FLUSH
//   dropped    out  1       sticky: in_valid seen while flushing
// -----------------------------------------------------------------------------
module hb_decim_ctrl #(
    parameter int DATA_W   = 10,
    parameter int FILL_LAT = 6,
    parameter int CNT_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_sample,
    output logic signed [DATA_W-1:0] e0_data,
    output logic signed [DATA_W-1:0] e1_data,
    output logic                     branch_en,
    output logic                     out_valid,
    output logic [1:0]               state,
    output logic                     dropped
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Counter value at which the next issued pair completes priming.
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_LAT - 1);
    // Counter value once every flush strobe has been issued.
    localparam logic [CNT_W-1:0] FLUSH_DONE = CNT_W'(FILL_LAT);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Saturating increment: the fill/flush counter never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_t                    state_r,    state_s;
    logic                      phase_r,    phase_s;
    logic [CNT_W-1:0]          cnt_r,      cnt_s;
    logic signed [DATA_W-1:0]  hold_r,     hold_s;
    logic signed [DATA_W-1:0]  e0_r,       e0_s;
    logic signed [DATA_W-1:0]  e1_r,       e1_s;
    logic                      br_r,       br_s;
    logic                      ov_r,       ov_s;
    logic                      dropped_r,  dropped_s;
    // Remembers whether the current flush follows RUN (tail outputs valid)
    // or FILL (primed data is never valid).
    logic                      from_run_r, from_run_s;

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        cnt_s      = cnt_r;
        hold_s     = hold_r;
        e0_s       = e0_r;
        e1_s       = e1_r;
        br_s       = 1'b0;
        ov_s       = 1'b0;
        dropped_s  = dropped_r;
        from_run_s = from_run_r;

        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_s    = FILL;
                    phase_s    = 1'b0;
                    cnt_s      = CNT_ZERO;
                    dropped_s  = 1'b0;
                    from_run_s = 1'b0;
                end else begin
                    state_s    = IDLE;
                end
            end

            FILL, RUN: begin
                // Pairing by valid count only; gaps simply hold the phase.
                if (in_valid) begin
                    if (phase_r) begin
                        e0_s    = hold_r;
                        e1_s    = in_sample;
                        br_s    = 1'b1;
                        phase_s = 1'b0;
                    end else begin
                        hold_s  = in_sample;
                        phase_s = 1'b1;
                    end
                end else begin
                    phase_s = phase_r;
                end

                if (state_r == RUN) begin
                    ov_s = br_r;
                end else begin
                    ov_s = 1'b0;
                end

                if (!enable) begin
                    // Stop: any half pair is discarded. A pair completing
                    // right now is still issued; its strobe is not part of
                    // the flush count, so the zero strobes start next cycle.
                    state_s    = FLUSH;
                    phase_s    = 1'b0;
                    from_run_s = (state_r == RUN);
                    if (in_valid && phase_r) begin
                        cnt_s = CNT_ZERO;
                    end else begin
                        e0_s  = '0;
                        e1_s  = '0;
                        br_s  = 1'b1;
                        cnt_s = CNT_ONE;
                    end
                end else if ((state_r == FILL) && in_valid && phase_r) begin
                    // Count priming strobes at issue time; the last one is
                    // already presented in RUN.
                    if (cnt_r == FILL_LAST) begin
                        state_s = RUN;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s   = sat_inc(cnt_r);
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end

            FLUSH: begin
                e0_s = '0;
                e1_s = '0;
                ov_s = from_run_r & br_r;
                if (in_valid) begin
                    dropped_s = 1'b1;
                end else begin
                    dropped_s = dropped_r;
                end
                if (cnt_r < FLUSH_DONE) begin
                    br_s  = 1'b1;
                    cnt_s = sat_inc(cnt_r);
                end else begin
                    // Last flush strobe is on the outputs now; enable is only
                    // looked at again once IDLE is reached.
                    state_s = IDLE;
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs, asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            phase_r    <= 1'b0;
            cnt_r      <= CNT_ZERO;
            hold_r     <= '0;
            e0_r       <= '0;
            e1_r       <= '0;
            br_r       <= 1'b0;
            ov_r       <= 1'b0;
            dropped_r  <= 1'b0;
            from_run_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            cnt_r      <= cnt_s;
            hold_r     <= hold_s;
            e0_r       <= e0_s;
            e1_r       <= e1_s;
            br_r       <= br_s;
            ov_r       <= ov_s;
            dropped_r  <= dropped_s;
            from_run_r <= from_run_s;
        end
    end

    assign e0_data   = e0_r;
    assign e1_data   = e1_r;
    assign branch_en = br_r;
    assign out_valid = ov_r;
    assign state     = state_r;
    assign dropped   = dropped_r;

endmodule

// File: tb/tb_hb_decim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hb_decim_ctrl
// Directed bench for hb_decim_ctrl. Inputs change 1 time unit after the rising
// edge and outputs are compared at that same point, after the edge has
// registered them.
// -----------------------------------------------------------------------------
module tb_hb_decim_ctrl;
    localparam int DATA_W   = 10;
    localparam int FILL_LAT = 6;
    localparam int CNT_W    = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     enable;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_sample;
    logic signed [DATA_W-1:0] e0_data;
    logic signed [DATA_W-1:0] e1_data;
    logic                     branch_en;
    logic                     out_valid;
    logic [1:0]               state;
    logic                     dropped;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hb_decim_ctrl #(
        .DATA_W   (DATA_W),
        .FILL_LAT (FILL_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .e0_data   (e0_data),
        .e1_data   (e1_data),
        .branch_en (branch_en),
        .out_valid (out_valid),
        .state     (state),
        .dropped   (dropped)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_sample = '0;
        #12;
        n_vec++;
        if ({state, branch_en, out_valid, dropped, e0_data, e1_data} !== '0) begin
            n_err++;
            $display("FAIL reset_init: state=%0d br=%b ov=%b drop=%b e0=%0d e1=%0d, want all 0",
                     state, branch_en, out_valid, dropped, e0_data, e1_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); cyc();
        n_vec++;
        if ({state, branch_en, out_valid} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_idle: state=%0d br=%b ov=%b, want 0/0/0", state, branch_en, out_valid);
        end
    endtask

    // Samples 1..16 back to back: 6th strobe (pair 11,12) enters RUN.
    task automatic test_back_to_back();
        logic [3:0] exp_ctl;
        logic [1:0] st;
        logic       b, o;
        enable = 1'b1;
        cyc();
        n_vec++;
        if (state !== S_FILL) begin
            n_err++;
            $display("FAIL b2b_enter_fill: state=%0d, want %0d", state, S_FILL);
        end
        for (int i = 1; i <= 17; i++) begin
            in_valid  = (i <= 16);
            in_sample = DATA_W'(i);
            cyc();
            st = (i >= 12) ? S_RUN : S_FILL;
            b  = (i <= 16) && (i % 2 == 0);
            o  = (i == 13) || (i == 15) || (i == 17);
            exp_ctl = {st, b, o};
            n_vec++;
            if ({state, branch_en, out_valid} !== exp_ctl) begin
                n_err++;
                $display("FAIL b2b_ctl i=%0d: state/br/ov=%b, want %b", i, {state, branch_en, out_valid}, exp_ctl);
            end
            if (b) begin
                n_vec++;
                if (e0_data !== DATA_W'(i - 1) || e1_data !== DATA_W'(i)) begin
                    n_err++;
                    $display("FAIL b2b_data i=%0d: e0=%0d e1=%0d, want %0d/%0d", i, e0_data, e1_data, i - 1, i);
                end
            end
        end
    endtask

    // Reset asserted between edges while in RUN.
    task automatic test_async_reset();
        #2;
        rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0;
        #1;
        n_vec++;
        if ({state, branch_en, out_valid, dropped, e0_data, e1_data} !== '0) begin
            n_err++;
            $display("FAIL async_reset: state=%0d br=%b ov=%b drop=%b e0=%0d e1=%0d, want all 0",
                     state, branch_en, out_valid, dropped, e0_data, e1_data);
        end
        cyc(); cyc();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); cyc(); cyc();
        n_vec++;
        if ({state, branch_en, out_valid} !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset_release: state=%0d br=%b ov=%b, want 0/0/0", state, branch_en, out_valid);
        end
    endtask

    // Samples -5..4, one every third cycle; ends in FILL after 5 strobes.
    task automatic test_gapped();
        logic signed [DATA_W-1:0] xa, xb;
        logic [3:0] exp_ctl;
        enable = 1'b1;
        cyc();
        for (int k = 0; k < 10; k++) begin
            in_valid  = 1'b1;
            in_sample = DATA_W'(k - 5);
            cyc();
            in_valid  = 1'b0;
            exp_ctl = {S_FILL, (k % 2 == 1), 1'b0};
            n_vec++;
            if ({state, branch_en, out_valid} !== exp_ctl) begin
                n_err++;
                $display("FAIL gap_ctl k=%0d: state/br/ov=%b, want %b", k, {state, branch_en, out_valid}, exp_ctl);
            end
            if (k % 2 == 1) begin
                xa = DATA_W'(k - 6);
                xb = DATA_W'(k - 5);
                n_vec++;
                if (e0_data !== xa || e1_data !== xb) begin
                    n_err++;
                    $display("FAIL gap_data k=%0d: e0=%0d e1=%0d, want %0d/%0d", k, e0_data, e1_data, xa, xb);
                end
            end
            for (int g = 0; g < 2; g++) begin
                cyc();
                n_vec++;
                if ({state, branch_en, out_valid} !== {S_FILL, 2'b00}) begin
                    n_err++;
                    $display("FAIL gap_idle k=%0d g=%0d: state/br/ov=%b, want %b",
                             k, g, {state, branch_en, out_valid}, {S_FILL, 2'b00});
                end
            end
        end
    endtask

    // 6th pair enters RUN, one odd sample, then stop: 6 zero strobes, 6 tail outputs.
    task automatic test_stop_run();
        logic [3:0] exp_ctl;
        in_valid = 1'b1; in_sample = 10'sd5; cyc();
        n_vec++;
        if ({state, branch_en, out_valid} !== {S_FILL, 2'b00}) begin
            n_err++;
            $display("FAIL run_s5: state/br/ov=%b, want %b", {state, branch_en, out_valid}, {S_FILL, 2'b00});
        end
        in_sample = 10'sd6; cyc();
        n_vec++;
        if ({state, branch_en, out_valid} !== {S_RUN, 2'b10} || e0_data !== 10'sd5 || e1_data !== 10'sd6) begin
            n_err++;
            $display("FAIL run_s6: state/br/ov=%b e0=%0d e1=%0d, want %b 5/6",
                     {state, branch_en, out_valid}, e0_data, e1_data, {S_RUN, 2'b10});
        end
        in_sample = 10'sd7; cyc();
        n_vec++;
        if ({state, branch_en, out_valid} !== {S_RUN, 2'b01}) begin
            n_err++;
            $display("FAIL run_s7: state/br/ov=%b, want %b", {state, branch_en, out_valid}, {S_RUN, 2'b01});
        end
        in_valid = 1'b0; enable = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            exp_ctl = {(c <= 6) ? S_FLUSH : S_IDLE, (c <= 6), (c >= 2) && (c <= 7)};
            n_vec++;
            if ({state, branch_en, out_valid} !== exp_ctl || e0_data !== '0 || e1_data !== '0) begin
                n_err++;
                $display("FAIL flush_run c=%0d: state/br/ov=%b e0=%0d e1=%0d, want %b 0/0",
                         c, {state, branch_en, out_valid}, e0_data, e1_data, exp_ctl);
            end
        end
    endtask

    // Stop after 3 priming strobes: 6 zero strobes, out_valid never set.
    task automatic test_stop_fill();
        logic [3:0] exp_ctl;
        enable = 1'b1;
        cyc();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_sample = DATA_W'(20 + i);
            cyc();
            exp_ctl = {S_FILL, (i % 2 == 1), 1'b0};
            n_vec++;
            if ({state, branch_en, out_valid} !== exp_ctl) begin
                n_err++;
                $display("FAIL fill_ctl i=%0d: state/br/ov=%b, want %b", i, {state, branch_en, out_valid}, exp_ctl);
            end
            if (i == 1) begin
                n_vec++;
                if (e0_data !== 10'sd20 || e1_data !== 10'sd21) begin
                    n_err++;
                    $display("FAIL fill_first_pair: e0=%0d e1=%0d, want 20/21", e0_data, e1_data);
                end
            end
        end
        in_valid = 1'b0; enable = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            exp_ctl = {(c <= 6) ? S_FLUSH : S_IDLE, (c <= 6), 1'b0};
            n_vec++;
            if ({state, branch_en, out_valid} !== exp_ctl || e0_data !== '0 || e1_data !== '0) begin
                n_err++;
                $display("FAIL flush_fill c=%0d: state/br/ov=%b e0=%0d e1=%0d, want %b 0/0",
                         c, {state, branch_en, out_valid}, e0_data, e1_data, exp_ctl);
            end
        end
    endtask

    // in_valid during FLUSH sets dropped; held in IDLE, cleared entering FILL.
    task automatic test_flush_drop();
        enable = 1'b1; cyc();
        in_valid = 1'b1; in_sample = 10'sd40; cyc();
        in_valid = 1'b0; enable = 1'b0; cyc();
        n_vec++;
        if ({state, branch_en, dropped} !== {S_FLUSH, 2'b10} || e0_data !== '0) begin
            n_err++;
            $display("FAIL drop_flush_c1: state/br/drop=%b e0=%0d, want %b 0",
                     {state, branch_en, dropped}, e0_data, {S_FLUSH, 2'b10});
        end
        in_valid = 1'b1; cyc();
        in_valid = 1'b0;
        for (int c = 2; c <= 7; c++) begin
            if (c > 2) cyc();
            n_vec++;
            if ({state, dropped} !== {(c <= 6) ? S_FLUSH : S_IDLE, 1'b1}) begin
                n_err++;
                $display("FAIL drop_hold c=%0d: state=%0d drop=%b, want %0d/1",
                         c, state, dropped, (c <= 6) ? S_FLUSH : S_IDLE);
            end
        end
        in_valid = 1'b1; cyc();
        in_valid = 1'b0;
        n_vec++;
        if ({state, branch_en, out_valid, dropped} !== {S_IDLE, 3'b001}) begin
            n_err++;
            $display("FAIL drop_idle_ignore: state/br/ov/drop=%b, want %b",
                     {state, branch_en, out_valid, dropped}, {S_IDLE, 3'b001});
        end
        enable = 1'b1; cyc();
        n_vec++;
        if ({state, dropped} !== {S_FILL, 1'b0}) begin
            n_err++;
            $display("FAIL drop_clear: state=%0d drop=%b, want 1/0", state, dropped);
        end
        in_valid = 1'b1; in_sample = 10'sd41; cyc();
        in_sample = 10'sd42; cyc();
        in_valid = 1'b0;
        n_vec++;
        if (branch_en !== 1'b1 || e0_data !== 10'sd41 || e1_data !== 10'sd42) begin
            n_err++;
            $display("FAIL half_pair_discard: br=%b e0=%0d e1=%0d, want 1 41/42", branch_en, e0_data, e1_data);
        end
    endtask

    // enable held high through FLUSH: IDLE for one cycle, then FILL.
    task automatic test_reenable();
        enable = 1'b0; cyc();
        enable = 1'b1;
        for (int c = 2; c <= 6; c++) cyc();
        n_vec++;
        if ({state, branch_en} !== {S_FLUSH, 1'b1}) begin
            n_err++;
            $display("FAIL reen_c6: state=%0d br=%b, want 3/1", state, branch_en);
        end
        cyc();
        n_vec++;
        if ({state, branch_en} !== {S_IDLE, 1'b0}) begin
            n_err++;
            $display("FAIL reen_idle: state=%0d br=%b, want 0/0", state, branch_en);
        end
        cyc();
        n_vec++;
        if (state !== S_FILL) begin
            n_err++;
            $display("FAIL reen_fill: state=%0d, want 1", state);
        end
    endtask

    // Pair completing on the stop cycle is still issued, then zero flush.
    task automatic test_pair_at_stop();
        bit seen_idle;
        in_valid = 1'b1; in_sample = 10'sd50; cyc();
        in_sample = 10'sd51; enable = 1'b0; cyc();
        in_valid = 1'b0;
        n_vec++;
        if ({state, branch_en} !== {S_FLUSH, 1'b1} || e0_data !== 10'sd50 || e1_data !== 10'sd51) begin
            n_err++;
            $display("FAIL stop_pair: state=%0d br=%b e0=%0d e1=%0d, want 3/1 50/51", state, branch_en, e0_data, e1_data);
        end
        cyc();
        n_vec++;
        if ({state, branch_en} !== {S_FLUSH, 1'b1} || e0_data !== '0 || e1_data !== '0) begin
            n_err++;
            $display("FAIL stop_pair_zero: state=%0d br=%b e0=%0d e1=%0d, want 3/1 0/0", state, branch_en, e0_data, e1_data);
        end
        seen_idle = 1'b0;
        for (int t = 0; t < 12 && !seen_idle; t++) begin
            cyc();
            if (state == S_IDLE) seen_idle = 1'b1;
        end
        n_vec++;
        if (!seen_idle) begin
            n_err++;
            $display("FAIL stop_pair_idle_timeout: state=%0d, want 0 within 12 cycles", state);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_async_reset();
        test_gapped();
        test_stop_run();
        test_stop_fill();
        test_flush_drop();
        test_reenable();
        test_pair_at_stop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
